// File: rtl/rom_reader.sv
`default_nettype none
// ============================================================================
// Module   : rom_reader
// Purpose  : Self-test sequencer for the one-hot-addressed ROM. It reads each
//            word and forwards it downstream over a valid/ready handshake,
//            keeping a running checksum and an expected-pattern check.
// Revision : 1.0  initial release
// ============================================================================
module rom_reader #(
    parameter int LAST_IDX = 7,
    parameter bit CHECK_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [7:0] rom_addr,
    output logic       rom_en,
    input  logic [7:0] rom_data,
    output logic [7:0] out_data,
    output logic [2:0] out_idx,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       done,
    output logic [7:0] checksum,
    output logic       mismatch
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_CAP  = 3'd2,
        S_OUT  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [2:0] C_LAST_IDX = 3'(LAST_IDX);

    state_t     r_state;
    state_t     w_next;
    logic [2:0] r_idx;
    logic [7:0] r_out_data;
    logic [2:0] r_out_idx;
    logic [7:0] r_checksum;
    logic       r_mismatch;
    logic [7:0] w_expected;

    // A healthy ROM holds 8'h11, 8'h22, ... 8'h88 at indices 0..7.
    assign w_expected = 8'h11 * ({5'd0, r_idx} + 8'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        rom_en    = 1'b0;
        rom_addr  = 8'h00;
        out_valid = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next = S_REQ;
                end
            end
            S_REQ: begin
                rom_en   = 1'b1;
                rom_addr = 8'h01 << r_idx;
                w_next   = S_CAP;
            end
            S_CAP: begin
                w_next = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = (r_idx == C_LAST_IDX) ? S_DONE : S_REQ;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= 3'd0;
            r_out_data <= 8'h00;
            r_out_idx  <= 3'd0;
            r_checksum <= 8'h00;
            r_mismatch <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_idx      <= 3'd0;
                        r_checksum <= 8'h00;
                        r_mismatch <= 1'b0;
                    end
                end
                S_CAP: begin
                    // ROM data is valid for the whole cycle after the request.
                    r_out_data <= rom_data;
                    r_out_idx  <= r_idx;
                    r_checksum <= r_checksum + rom_data;
                    if (CHECK_EN && (rom_data != w_expected)) begin
                        r_mismatch <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (out_ready && (r_idx != C_LAST_IDX)) begin
                        r_idx <= r_idx + 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_data = r_out_data;
    assign out_idx  = r_out_idx;
    assign checksum = r_checksum;
    assign mismatch = r_mismatch;

endmodule
`default_nettype wire

// File: tb/tb_rom_reader.sv
`default_nettype none
// Testbench for rom_reader: registered ROM model, scoreboard of expected words
// pushed on each ROM request and popped on each downstream handshake.
module tb_rom_reader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, start2;
    logic [7:0] rom_addr, rom_addr2;
    logic       rom_en, rom_en2;
    logic [7:0] rom_data, rom_data2;
    logic [7:0] out_data, out_data2;
    logic [2:0] out_idx, out_idx2;
    logic       out_valid, out_valid2;
    logic       out_ready;
    logic       busy, busy2;
    logic       done, done2;
    logic [7:0] checksum, checksum2;
    logic       mismatch, mismatch2;
    bit         corrupt;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [7:0] data;
        logic [2:0] idx;
        logic       mm;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    rom_reader dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .rom_addr(rom_addr), .rom_en(rom_en), .rom_data(rom_data),
        .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done),
        .checksum(checksum), .mismatch(mismatch)
    );

    rom_reader #(.LAST_IDX(2), .CHECK_EN(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .rom_addr(rom_addr2), .rom_en(rom_en2), .rom_data(rom_data2),
        .out_data(out_data2), .out_idx(out_idx2), .out_valid(out_valid2),
        .out_ready(1'b1), .busy(busy2), .done(done2),
        .checksum(checksum2), .mismatch(mismatch2)
    );

    function automatic logic [7:0] rom_word(input logic [7:0] a, input bit bad);
        logic [7:0] w;
        logic [7:0] one;
        w   = 8'h00;
        one = 8'h01;
        for (int i = 0; i < 8; i++)
            if (a == (one << i)) w = 8'(8'h11 * (i + 1));
        if (bad && a == 8'h10) w = 8'h00;
        return w;
    endfunction

    function automatic logic [7:0] exp_word(input int idx, input bit bad);
        if (bad && idx == 4) return 8'h00;
        return 8'(8'h11 * (idx + 1));
    endfunction

    // Registered ROM with clear-on-disable, one cycle latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_data  <= 8'h00;
            rom_data2 <= 8'h00;
        end else begin
            rom_data  <= rom_en  ? rom_word(rom_addr, corrupt) : 8'h00;
            rom_data2 <= rom_en2 ? rom_word(rom_addr2, 1'b0)   : 8'h00;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Scoreboard monitor
    int         mon_idx;
    logic [7:0] run_sum;
    logic       prev_en;
    always @(negedge clk) begin
        exp_t       e;
        logic [7:0] one;
        one = 8'h01;
        if (!rst_n || !busy) begin
            sb.delete();
            mon_idx = 0;
            run_sum = 8'h00;
            prev_en = 1'b0;
        end else begin
            if (rom_en) begin
                check("rom_en_single", {31'd0, prev_en}, 32'd0);
                check("rom_addr", {24'd0, rom_addr}, {24'd0, one << mon_idx});
                e.data = exp_word(mon_idx, corrupt);
                e.idx  = 3'(mon_idx);
                e.mm   = corrupt && (mon_idx >= 4);
                sb.push_back(e);
                mon_idx++;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    run_sum = run_sum + e.data;
                    check("out_data", {24'd0, out_data}, {24'd0, e.data});
                    check("out_idx", {29'd0, out_idx}, {29'd0, e.idx});
                    check("mismatch_run", {31'd0, mismatch}, {31'd0, e.mm});
                    check("checksum_run", {24'd0, checksum}, {24'd0, run_sum});
                end
            end
            if (done) check("sb_empty_at_done", sb.size(), 32'd0);
            prev_en = rom_en;
        end
    end

    // Runs one scan on dut; returns cycles from the start cycle to the done pulse.
    task automatic run_scan(input int stall_idx, input int stall_len, input bit poke, output int cyc);
        int stalled;
        stalled = 0;
        @(posedge clk); #1;
        start     = 1'b1;
        out_ready = 1'b1;
        cyc = 0;
        @(negedge clk);
        while (1) begin
            @(posedge clk); #1;
            start = poke && (cyc + 1 == 9);
            if (out_valid && int'(out_idx) == stall_idx && stalled < stall_len) begin
                out_ready = 1'b0;
                stalled++;
            end else begin
                out_ready = 1'b1;
            end
            @(negedge clk);
            cyc++;
            if (out_valid && !out_ready) begin
                check("stall_data", {24'd0, out_data}, {24'd0, exp_word(stall_idx, corrupt)});
                check("stall_idx", {29'd0, out_idx}, stall_idx);
                check("stall_no_rom", {31'd0, rom_en}, 32'd0);
            end
            if (done) break;
            if (cyc > 200) begin
                check("scan_timeout", 32'd1, 32'd0);
                break;
            end
        end
        start     = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        int cyc;
        int n2;
        int cnt2;
        logic [7:0] or2;
        rst_n = 1'b0; start = 1'b0; start2 = 1'b0; out_ready = 1'b1; corrupt = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rom_addr", {24'd0, rom_addr}, 32'd0);
        check("rst_rom_en", {31'd0, rom_en}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        check("rst_out_idx", {29'd0, out_idx}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_checksum", {24'd0, checksum}, 32'd0);
        check("rst_mismatch", {31'd0, mismatch}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Healthy scan
        run_scan(-1, 0, 1'b0, cyc);
        check("healthy_cycles", cyc, 25);
        check("healthy_checksum", {24'd0, checksum}, 32'h64);
        check("healthy_mismatch", {31'd0, mismatch}, 32'd0);

        // Backpressure at idx 3
        run_scan(3, 5, 1'b0, cyc);
        check("stall_cycles", cyc, 30);
        check("stall_checksum", {24'd0, checksum}, 32'h64);

        // Corrupt word at addr 8'h10
        corrupt = 1'b1;
        run_scan(-1, 0, 1'b0, cyc);
        check("corrupt_cycles", cyc, 25);
        check("corrupt_checksum", {24'd0, checksum}, 32'h0F);
        check("corrupt_mismatch", {31'd0, mismatch}, 32'd1);
        repeat (3) @(negedge clk);
        check("sticky_mismatch", {31'd0, mismatch}, 32'd1);
        check("sticky_checksum", {24'd0, checksum}, 32'h0F);
        corrupt = 1'b0;

        // Clean rescan with start poked during OUT of idx 2
        run_scan(-1, 0, 1'b1, cyc);
        check("poke_cycles", cyc, 25);
        check("poke_checksum", {24'd0, checksum}, 32'h64);
        check("poke_mismatch", {31'd0, mismatch}, 32'd0);
        @(negedge clk);
        check("idle_after_done", {31'd0, busy}, 32'd0);

        // Async reset while requesting idx 5
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cyc = 0;
        while (!(rom_en && rom_addr == 8'h20) && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("reached_idx5", {31'd0, rom_en}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_rom_en", {31'd0, rom_en}, 32'd0);
        check("arst_rom_addr", {24'd0, rom_addr}, 32'd0);
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_idle", {31'd0, busy}, 32'd0);
            check("post_rst_no_rom", {31'd0, rom_en}, 32'd0);
        end
        run_scan(-1, 0, 1'b0, cyc);
        check("post_rst_cycles", cyc, 25);
        check("post_rst_checksum", {24'd0, checksum}, 32'h64);

        // LAST_IDX = 2 instance
        @(posedge clk); #1 start2 = 1'b1;
        @(negedge clk);
        n2 = 0; cnt2 = 0; or2 = 8'h00;
        while (n2 < 60) begin
            @(posedge clk); #1 start2 = 1'b0;
            @(negedge clk);
            n2++;
            if (rom_en2) begin
                cnt2++;
                or2 = or2 | rom_addr2;
            end
            if (done2) break;
        end
        check("li2_cycles", n2, 10);
        check("li2_reads", cnt2, 3);
        check("li2_addrs", {24'd0, or2}, 32'h07);
        check("li2_checksum", {24'd0, checksum2}, 32'h66);
        check("li2_mismatch", {31'd0, mismatch2}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rom_reader.md
# rom_reader

Initiator for the one-hot-addressed ROM interface. On `start` it walks one-hot addresses 8'h01 through 8'h80, issues single-cycle enabled reads, and captures each returned byte after the ROM's one-cycle registered latency. Each word goes downstream over a valid/ready handshake, with a running checksum and an expected-pattern check. It sits between the ROM and the board-level display/UART logic, and serves as the ROM's self-test sequencer.

## Interface
Parameters:
- `LAST_IDX`, default 7: index of the final word read; a scan covers indices 0..LAST_IDX; legal range 0..7.
- `CHECK_EN`, default 1: 1 enables the expected-pattern compare; 0 holds `mismatch` at 0.

Ports:
- `clk`  in  1  system clock; all flops on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a scan; sampled only in IDLE.
- `rom_addr`  out  8  one-hot ROM address; `8'h01 << idx` during REQ, otherwise 8'h00.
- `rom_en`  out  1  ROM read enable; high only in REQ.
- `rom_data`  in  8  ROM read data; valid the cycle after REQ.
- `out_data`  out  8  captured word.
- `out_idx`  out  3  index of `out_data`.
- `out_valid`  out  1  word available.
- `out_ready`  in  1  downstream accepts the word.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at scan completion.
- `checksum`  out  8  sum mod 256 of all words captured this scan.
- `mismatch`  out  1  sticky flag: some captured word differed from its expected value.

## Operation
States are IDLE, REQ, CAP, OUT and DONE.
- **IDLE:** when `start`=1, clear `checksum`, `mismatch` and `idx`, then go to REQ.
- **REQ (1 cycle):** drive `rom_en`=1 and `rom_addr`=`8'h01<<idx`; go to CAP.
- **CAP (1 cycle):**
  - Drive `rom_en`=0.
  - At the end of the cycle, load `out_data`<=`rom_data` and `out_idx`<=`idx`.
  - Update `checksum`<=`checksum+rom_data`, truncated to 8 bits.
  - If `CHECK_EN` and `rom_data` != `8'h11*(idx+1)` (8-bit), set `mismatch`.
  - Go to OUT.
- **OUT:** hold `out_valid`=1, with `out_data` and `out_idx` stable, until `out_ready`=1.
  - On handshake with `idx`==`LAST_IDX`, go to DONE.
  - On handshake otherwise, `idx`<=`idx+1` and go to REQ.
- **DONE (1 cycle):** `done`=1; go to IDLE.
- `start` is ignored outside IDLE; there is no restart or abort mid-scan.
- `mismatch` and `checksum` hold their values after DONE until the next accepted `start`.
- Index arithmetic is 3 bits. `idx` never exceeds `LAST_IDX`, so there is no wrap.
- With `CHECK_EN`=0, `mismatch` stays 0; the checksum is still computed.

## Timing
- Reset values: state IDLE, `rom_addr` 8'h00, `rom_en` 0, `out_data` 8'h00, `out_idx` 0, `out_valid` 0, `busy` 0, `done` 0, `checksum` 8'h00, `mismatch` 0.
- All outputs are registered or decoded from registered state; no input-to-output combinational path.
- ROM latency is fixed at 1 cycle:
  - The ROM samples addr/en at the edge ending REQ.
  - `rom_data` is valid throughout CAP and is captured at the edge ending CAP.
  - Deasserting `rom_en` in CAP is safe because the ROM's clear-on-disable takes effect only after that edge.
- Per-word cost is 3 cycles (REQ, CAP, OUT) when `out_ready` is held high.
  - A full 8-word scan runs `start` accepted → `done` pulse in 1 + 8×3 = 25 cycles.
  - The `done` pulse occurs in the 25th cycle after the `start` cycle.
- Backpressure: OUT may last any number of cycles, and `out_data` must not change while `out_valid`=1 and `out_ready`=0.
- `out_valid` drops in the cycle after the handshake.
- `start` high in the DONE cycle is ignored. `start` held high continuously gives back-to-back scans, with one IDLE cycle between them.
- Reset asserted mid-scan immediately forces all outputs to reset values. No ROM read is pending after reset.

## Test plan
- **Healthy ROM, `out_ready`=1, `start` pulse:**
  - `rom_addr` sequence is 01,02,04,…,80, each with `rom_en` for exactly 1 cycle.
  - `out_data` sequence is 11,22,…,88.
  - `done` pulses 25 cycles after `start`; `checksum`=8'h64 and `mismatch`=0.
- **Backpressure:** hold `out_ready`=0 for 5 cycles at idx 3.
  - `out_valid`=1 with `out_data`=8'h44 and `out_idx`=3 stable throughout.
  - No ROM access occurs during the stall; the scan completes 5 cycles later.
- **Corrupt word:** ROM model returns 8'h00 at addr 8'h10.
  - `mismatch` rises after CAP of idx 4 and stays 1.
  - Final `checksum`=8'h0F.
  - The next `start` clears both flags; a clean rescan gives `mismatch`=0.
- **Start ignored mid-scan:** pulse `start` during the OUT state of idx 2.
  - Scan order, checksum and `done` timing are unchanged.
- **Async reset at idx 5, in REQ:** drop `rst_n` between clock edges.
  - `rom_en`, `rom_addr`, `out_valid` and `busy` go to 0 immediately, without waiting for an edge.
  - After release, the block stays in IDLE until `start`, and a new scan begins at addr 8'h01.
- **`LAST_IDX`=2:**
  - Only addresses 01,02,04 are read.
  - `done` pulses after 10 cycles; `checksum`=8'h66.
